// File: rtl/secure_mem_pkg.sv
// Shared types and constants for the secure readout buffer.
// Holds the two-state scrub/idle encoding and the zero word used for zeroization.
package secure_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } state_t;

    localparam int unsigned   MAX_WORD_W = 64;
    localparam logic [63:0]   ZERO_WORD  = '0;

endpackage

// File: rtl/secure_readout_buffer.sv
// Zeroizing show-ahead FIFO: popped entries are wiped, and a full scrub runs after reset or on request.
// Pop latency 0 (show-ahead), push-to-pop 1 cycle; pushes during scrub or when full are dropped with a pulse.
module secure_readout_buffer
    import secure_mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_full,
    output logic                       wr_drop,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       scrub_req,
    output logic                       scrub_busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] ZERO     = ZERO_WORD[WIDTH-1:0];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_scrub_idx;
    logic [AW:0]        r_count;
    logic               r_wr_drop;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_idle;
    logic               w_scrub_wr;
    logic               w_scrub_last;
    logic               w_pop;
    logic               w_push;
    logic               w_drop_nxt;
    logic [AW-1:0]      w_wr_ptr_nxt;
    logic [AW-1:0]      w_rd_ptr_nxt;
    logic [AW-1:0]      w_scrub_idx_nxt;
    logic [AW:0]        w_count_nxt;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_scrub_wr   = (r_state == ST_SCRUB);
    assign w_scrub_last = w_scrub_wr && (r_scrub_idx == LAST_IDX);

    assign rd_valid   = w_idle && (r_count != '0);
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : ZERO;
    assign wr_full    = (r_count == FULL_CNT);
    assign wr_drop    = r_wr_drop;
    assign scrub_busy = w_scrub_wr;
    assign count      = r_count;

    // A pop frees a slot in the same cycle, so a full buffer can still accept a push alongside it.
    assign w_pop  = rd_valid && rd_ready;
    assign w_push = w_idle && wr_en && ((r_count != FULL_CNT) || w_pop);

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_scrub_idx_nxt = r_scrub_idx;
        w_count_nxt     = r_count;
        w_drop_nxt      = wr_en && !w_push;

        case (r_state)
            ST_SCRUB: begin
                w_scrub_idx_nxt = r_scrub_idx + PTR_ONE;
                if (w_scrub_last) begin
                    w_scrub_idx_nxt = '0;
                    w_wr_ptr_nxt    = '0;
                    w_rd_ptr_nxt    = '0;
                    w_count_nxt     = '0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                if (w_push) begin
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    w_count_nxt = r_count + CNT_ONE;
                end else if (w_pop && !w_push) begin
                    w_count_nxt = r_count - CNT_ONE;
                end
                // Transfers in the request cycle still complete; the scrub wipes them afterwards.
                if (scrub_req) begin
                    w_state_nxt = ST_SCRUB;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCRUB;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_scrub_idx <= '0;
            r_count     <= '0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_scrub_idx <= w_scrub_idx_nxt;
            r_count     <= w_count_nxt;
            r_wr_drop   <= w_drop_nxt;
        end
    end

    // Storage has no reset; the post-reset scrub clears it. Push is last so it wins over a same-slot wipe.
    always_ff @(posedge clk) begin
        if (w_scrub_wr) begin
            r_mem[r_scrub_idx] <= ZERO;
        end
        if (w_pop) begin
            r_mem[r_rd_ptr] <= ZERO;
        end
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_secure_readout_buffer.sv
// Randomized and directed bench for secure_readout_buffer against a queue-based model.
module tb_secure_readout_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_full;
    logic       wr_drop;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       scrub_req;
    logic       scrub_busy;
    logic [4:0] count;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] m_q[$];
    int         m_busy_left;
    logic       m_drop;
    bit         chk_on = 1'b0;

    secure_readout_buffer #(.WIDTH(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .wr_drop    (wr_drop),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .scrub_req  (scrub_req),
        .scrub_busy (scrub_busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy_left = 16;
        m_drop = 1'b0;
    endtask

    // One clock of the buffer's rules, in queue terms.
    task automatic model_step();
        bit pop, push;
        if (m_busy_left > 0) begin
            m_drop = wr_en;
            m_busy_left--;
            if (m_busy_left == 0) m_q.delete();
        end else begin
            pop  = (m_q.size() != 0) && rd_ready;
            push = wr_en && ((m_q.size() < 16) || pop);
            m_drop = wr_en && !push;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(wr_data);
            if (scrub_req) m_busy_left = 16;
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic       ev;
            logic [7:0] ed;
            ev = (m_busy_left == 0) && (m_q.size() != 0);
            ed = ev ? m_q[0] : 8'h00;
            chk("count",      32'(count),      32'(m_q.size()));
            chk("wr_full",    32'(wr_full),    32'(m_q.size() == 16));
            chk("rd_valid",   32'(rd_valid),   32'(ev));
            chk("rd_data",    32'(rd_data),    32'(ed));
            chk("scrub_busy", 32'(scrub_busy), 32'(m_busy_left > 0));
            chk("wr_drop",    32'(wr_drop),    32'(m_drop));
        end
    end

    task automatic cyc(input logic we, input logic [7:0] wd, input logic rr, input logic sr);
        wr_en = we; wr_data = wd; rd_ready = rr; scrub_req = sr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_scrub(input logic we, output int n, output int drops);
        n = 0; drops = 0;
        while (scrub_busy && n < 40) begin
            n++;
            cyc(we, 8'h00, 1'b0, 1'b0);
            drops += int'(wr_drop);
        end
    endtask

    initial begin
        int n, drops, np, npop;
        logic [7:0] w, second;
        bit pre_pop, pre_push, we, rr;

        rst_n = 1'b0; wr_en = 0; wr_data = 0; rd_ready = 0; scrub_req = 0;
        model_reset();
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(scrub_busy), 1);
        chk("reset_count", 32'(count), 0);
        rst_n = 1'b1;

        // 1: post-reset scrub with pushes hammering
        wait_scrub(1'b1, n, drops);
        chk("t1_busy_cycles", n, 16);
        chk("t1_drops", drops, 16);
        cyc(0, 0, 0, 0);
        chk("t1_count", 32'(count), 0);
        chk("t1_rd_valid", 32'(rd_valid), 0);

        // 2: three pushes, ordered drain, slots wiped
        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hB2, 0, 0);
        cyc(1, 8'hC3, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t2_count", 32'(count), 3);
        chk("t2_rd0", 32'(rd_data), 32'h A1);
        cyc(0, 0, 1, 0);
        chk("t2_rd1", 32'(rd_data), 32'h B2);
        cyc(0, 0, 1, 0);
        chk("t2_rd2", 32'(rd_data), 32'h C3);
        cyc(0, 0, 1, 0);
        chk("t2_rd_empty", 32'(rd_data), 0);
        for (int i = 0; i < 3; i++) chk("t2_mem_zero", 32'(dut.r_mem[i]), 0);

        // 3: fill, overflow drop, push+pop while full
        second = 8'h00;
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            if (i == 1) second = w;
            cyc(1, w, 0, 0);
        end
        chk("t3_full", 32'(wr_full), 1);
        cyc(1, 8'h5A, 0, 0);
        chk("t3_drop", 32'(wr_drop), 1);
        chk("t3_count16", 32'(count), 16);
        cyc(1, 8'h77, 1, 0);
        chk("t3_pp_count", 32'(count), 16);
        chk("t3_pp_head", 32'(rd_data), 32'(second));
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
        chk("t3_drained", 32'(count), 0);

        // 4: 20 pushes and 20 pops interleaved
        np = 0; npop = 0;
        for (int i = 0; i < 400 && (np < 20 || npop < 20); i++) begin
            we = (np < 20) && ($urandom_range(0, 1) == 1);
            rr = (npop < 20) && ($urandom_range(0, 1) == 1);
            pre_pop  = rr && (m_q.size() != 0) && (m_busy_left == 0);
            pre_push = we && ((m_q.size() < 16) || pre_pop);
            np += int'(pre_push);
            npop += int'(pre_pop);
            cyc(we, 8'($urandom), rr, 0);
        end
        chk("t4_pushes", np, 20);
        chk("t4_final_count", 32'(count), 0);

        // Random traffic with occasional scrub requests
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0);
        wait_scrub(1'b0, n, drops);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);

        // 5: requested scrub wipes everything
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        chk("t5_count5", 32'(count), 5);
        cyc(0, 0, 0, 1);
        wait_scrub(1'b0, n, drops);
        chk("t5_busy_cycles", n, 16);
        chk("t5_count", 32'(count), 0);
        for (int i = 0; i < 16; i++) chk("t5_mem_zero", 32'(dut.r_mem[i]), 0);

        // 6: reset mid-drain
        for (int i = 0; i < 6; i++) cyc(1, 8'(8'h60 + i), 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t6_count4", 32'(count), 4);
        rd_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_valid", 32'(rd_valid), 0);
        chk("t6_rst_data", 32'(rd_data), 0);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_busy", 32'(scrub_busy), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_scrub(1'b0, n, drops);
        chk("t6_busy_cycles", n, 16);
        cyc(0, 0, 0, 0);
        chk("t6_empty", 32'(count), 0);
        chk("t6_rd_valid", 32'(rd_valid), 0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
